sse_result_packer: RTL and testbench

Downstream consumer of the sum-of-squared-error collector in the batch word-length evaluation path. Each single-cycle 64-bit error result is tagged with the configuration ID under test and compared against a programmed threshold. The result is queued in a small FIFO and serialized as a fixed byte packet over a valid/ready byte stream toward the host link. In parallel, the block tracks the minimum error seen and its configuration ID since the last clear.

---
 rtl/sse_result_packer_if.sv | 9 +
 rtl/sse_result_packer.sv | 112 +++++++++++
 tb/tb_sse_result_packer.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sse_result_packer_if.sv
// Byte-stream handshake from the result packer toward the host link.
interface sse_result_packer_if;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       byte_ready;

    modport master (output byte_out, byte_valid, input byte_ready);
    modport slave  (input byte_out, byte_valid, output byte_ready);
endinterface

// File: rtl/sse_result_packer.sv
// Queues tagged SSE results with a pass flag and serializes each as a fixed byte packet;
// tracks the minimum error and its configuration ID since the last clear.
module sse_result_packer #(
    parameter int DEPTH = 4,
    parameter int CFG_W = 16
) (
    input  logic                    clk,
    input  logic                    rstn,
    input  logic [63:0]             err_in,
    input  logic                    err_valid,
    input  logic [CFG_W-1:0]        cfg_id,
    input  logic [63:0]             threshold,
    input  logic                    clear,
    sse_result_packer_if.master     bif,
    output logic [63:0]             best_err,
    output logic [CFG_W-1:0]        best_id,
    output logic                    best_valid,
    output logic                    last_pass,
    output logic                    overflow,
    output logic [$clog2(DEPTH):0]  fifo_count
);
    localparam int IDB   = CFG_W / 8;
    localparam int N     = 2 + IDB + 8;
    localparam int PKT_W = 8 * N;
    localparam int AW    = $clog2(DEPTH);
    localparam int IW    = $clog2(N);

    typedef struct packed {
        logic [CFG_W-1:0] id;
        logic [63:0]      err;
        logic             pass;
    } entry_t;

    typedef enum logic {IDLE, SEND} state_t;

    entry_t           mem [DEPTH];
    logic [AW-1:0]    wr_ptr, rd_ptr;
    logic             ne_q;
    state_t           state;
    logic [PKT_W-1:0] pkt;
    logic [IW-1:0]    idx;

    logic pass, full, push, pop, last;

    assign pass = (err_in <= threshold);
    assign full = (fifo_count == (AW+1)'(DEPTH));
    assign push = err_valid && !full;
    // The serializer looks at a registered non-empty view, which sets the
    // two-edge first-byte latency and the single bubble between packets.
    assign pop  = (state == IDLE) && ne_q && (fifo_count != '0);
    assign last = (idx == IW'(N-1));

    assign bif.byte_out   = pkt[PKT_W-1 -: 8];
    assign bif.byte_valid = (state == SEND);

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= '{id: cfg_id, err: err_in, pass: pass};
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_count <= '0;
            ne_q       <= 1'b0;
            state      <= IDLE;
            pkt        <= '0;
            idx        <= '0;
            best_err   <= '0;
            best_id    <= '0;
            best_valid <= 1'b0;
            last_pass  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr    <= wr_ptr + 1'b1;
                last_pass <= pass;
            end
            fifo_count <= fifo_count + (AW+1)'(push) - (AW+1)'(pop);
            ne_q       <= (fifo_count != '0);

            // A result arriving with clear is queued but never becomes best.
            if (clear) begin
                best_err   <= '0;
                best_id    <= '0;
                best_valid <= 1'b0;
            end else if (err_valid && (!best_valid || err_in < best_err)) begin
                best_err   <= err_in;
                best_id    <= cfg_id;
                best_valid <= 1'b1;
            end

            if (err_valid && full) overflow <= 1'b1;
            else if (clear)        overflow <= 1'b0;

            case (state)
                IDLE: if (pop) begin
                    pkt    <= {8'hA5, mem[rd_ptr].id, mem[rd_ptr].err, 7'b0, mem[rd_ptr].pass};
                    idx    <= '0;
                    rd_ptr <= rd_ptr + 1'b1;
                    state  <= SEND;
                end
                SEND: if (bif.byte_ready) begin
                    // Shifting in zeros leaves byte_out at 0 once the packet is done.
                    pkt <= {pkt[PKT_W-9:0], 8'h00};
                    idx <= idx + 1'b1;
                    if (last) state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_sse_result_packer.sv
// Randomized and directed checks of sse_result_packer against a packet/best-tracker model.
module tb_sse_result_packer;
    localparam int DEPTH = 4;
    localparam int CFG_W = 16;
    localparam int IDB   = CFG_W / 8;
    localparam int N     = 2 + IDB + 8;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic [63:0] err_in = '0, threshold = '0;
    logic [CFG_W-1:0] cfg_id = '0;
    logic err_valid = 1'b0, clear = 1'b0, ready = 1'b0;
    logic [63:0] best_err;
    logic [CFG_W-1:0] best_id;
    logic best_valid, last_pass, overflow;
    logic [$clog2(DEPTH):0] fifo_count;

    int n_run = 0, n_fail = 0;
    logic [7:0] got[$], exp[$];
    logic [63:0] m_best = '0;
    logic [CFG_W-1:0] m_id = '0;
    logic m_bv = 1'b0, m_pass = 1'b0;

    always #5 clk = ~clk;

    sse_result_packer_if bif ();
    assign bif.byte_ready = ready;

    sse_result_packer #(.DEPTH(DEPTH), .CFG_W(CFG_W)) dut (
        .clk(clk), .rstn(rstn), .err_in(err_in), .err_valid(err_valid), .cfg_id(cfg_id),
        .threshold(threshold), .clear(clear), .bif(bif), .best_err(best_err), .best_id(best_id),
        .best_valid(best_valid), .last_pass(last_pass), .overflow(overflow), .fifo_count(fifo_count)
    );

    // Inputs change 1ns after posedge, so the negedge view is what the next edge samples.
    always @(negedge clk)
        if (rstn && bif.byte_valid && ready) got.push_back(bif.byte_out);

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic add_exp(input logic [63:0] e, input logic [CFG_W-1:0] id, input logic p);
        exp.push_back(8'hA5);
        for (int i = IDB-1; i >= 0; i--) exp.push_back(8'((id >> (8*i)) & 'hFF));
        for (int i = 7; i >= 0; i--) exp.push_back(8'((e >> (8*i)) & 64'hFF));
        exp.push_back({7'b0, p});
    endtask

    task automatic strobe(input logic [63:0] e, input logic [CFG_W-1:0] id, input logic [63:0] thr,
                          input logic clr, input logic pushed);
        err_in = e; cfg_id = id; threshold = thr; clear = clr; err_valid = 1'b1;
        tick();
        err_valid = 1'b0; clear = 1'b0;
        if (clr) begin m_bv = 1'b0; m_best = '0; m_id = '0; end
        else if (!m_bv || e < m_best) begin m_bv = 1'b1; m_best = e; m_id = id; end
        if (pushed) begin m_pass = (e <= thr); add_exp(e, id, m_pass); end
    endtask

    task automatic wait_drain(input int budget);
        int k = 0;
        ready = 1'b1;
        while (got.size() < exp.size() && k < budget) begin tick(); k++; end
        repeat (4) tick();
    endtask

    task automatic test_reset();
        rstn = 1'b0; ready = 1'b0;
        repeat (3) tick();
        n_run++; if (bif.byte_valid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", bif.byte_valid); end
        n_run++; if (bif.byte_out !== 8'h00) begin n_fail++; $display("FAIL rst_byte: got %h want 00", bif.byte_out); end
        n_run++; if (fifo_count !== '0) begin n_fail++; $display("FAIL rst_count: got %0d want 0", fifo_count); end
        n_run++; if ({best_valid, last_pass, overflow} !== 3'b000) begin n_fail++; $display("FAIL rst_flags: got %b want 000", {best_valid, last_pass, overflow}); end
        n_run++; if (best_err !== '0 || best_id !== '0) begin n_fail++; $display("FAIL rst_best: got %h/%h want 0/0", best_err, best_id); end
        rstn = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int cnt;
        ready = 1'b1;
        strobe(64'h0000_0001_2345_6789, 16'h00C3, 64'h1_0000_0000, 1'b0, 1'b0);
        exp = '{8'hA5, 8'h00, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'h00};
        n_run++; if (fifo_count !== 1) begin n_fail++; $display("FAIL single_count: got %0d want 1", fifo_count); end
        n_run++; if (last_pass !== 1'b0) begin n_fail++; $display("FAIL single_pass: got %b want 0", last_pass); end
        n_run++; if (best_err !== m_best || best_id !== m_id || best_valid !== 1'b1) begin n_fail++; $display("FAIL single_best: got %h/%h want %h/%h", best_err, best_id, m_best, m_id); end
        n_run++; if (bif.byte_valid !== 1'b0) begin n_fail++; $display("FAIL single_lat1: got %b want 0", bif.byte_valid); end
        tick();
        n_run++; if (bif.byte_valid !== 1'b0) begin n_fail++; $display("FAIL single_lat2: got %b want 0", bif.byte_valid); end
        tick();
        n_run++; if (bif.byte_valid !== 1'b1 || bif.byte_out !== 8'hA5) begin n_fail++; $display("FAIL single_first: got %b/%h want 1/a5", bif.byte_valid, bif.byte_out); end
        cnt = 1;
        repeat (N + 2) begin tick(); if (bif.byte_valid) cnt++; end
        n_run++; if (cnt != N) begin n_fail++; $display("FAIL single_cycles: got %0d want %0d", cnt, N); end
        wait_drain(100);
        n_run++; if (got.size() != exp.size()) begin n_fail++; $display("FAIL single_len: got %0d want %0d", got.size(), exp.size()); end
        foreach (exp[i]) begin
            n_run++;
            if (i >= got.size() || got[i] !== exp[i]) begin n_fail++; $display("FAIL single_byte[%0d]: got %h want %h", i, (i < got.size()) ? got[i] : 8'h00, exp[i]); end
        end
        got.delete(); exp.delete();
    endtask

    task automatic test_pass_boundary();
        int first = -1, lst = -1, cnt = 0;
        ready = 1'b1;
        strobe(64'h10, 16'h0011, 64'h10, 1'b0, 1'b1);
        n_run++; if (last_pass !== 1'b1) begin n_fail++; $display("FAIL pb_pass_eq: got %b want 1", last_pass); end
        strobe(64'h11, 16'h0012, 64'h10, 1'b0, 1'b1);
        n_run++; if (last_pass !== 1'b0) begin n_fail++; $display("FAIL pb_pass_gt: got %b want 0", last_pass); end
        for (int t = 0; t < 40; t++) begin
            if (bif.byte_valid) begin if (first < 0) first = t; lst = t; cnt++; end
            tick();
        end
        n_run++; if (cnt != 2*N) begin n_fail++; $display("FAIL pb_valid_cycles: got %0d want %0d", cnt, 2*N); end
        n_run++; if (lst - first + 1 != 2*N + 1) begin n_fail++; $display("FAIL pb_bubble_span: got %0d want %0d", lst - first + 1, 2*N + 1); end
        wait_drain(100);
        n_run++; if (got.size() != exp.size()) begin n_fail++; $display("FAIL pb_len: got %0d want %0d", got.size(), exp.size()); end
        foreach (exp[i]) begin
            n_run++;
            if (i >= got.size() || got[i] !== exp[i]) begin n_fail++; $display("FAIL pb_byte[%0d]: got %h want %h", i, (i < got.size()) ? got[i] : 8'h00, exp[i]); end
        end
        got.delete(); exp.delete();
    endtask

    task automatic test_backpressure();
        logic pv = 1'b0, pr = 1'b0;
        logic [7:0] pb = '0;
        int k = 0;
        ready = 1'b0;
        strobe(64'h0000_0001_2345_6789, 16'h00C3, 64'h1_0000_0000, 1'b0, 1'b0);
        exp = '{8'hA5, 8'h00, 8'hC3, 8'h00, 8'h00, 8'h00, 8'h01, 8'h23, 8'h45, 8'h67, 8'h89, 8'h00};
        while (got.size() < N && k < 200) begin
            if (pv && !pr) begin
                n_run++;
                if (bif.byte_valid !== 1'b1 || bif.byte_out !== pb) begin n_fail++; $display("FAIL bp_hold: got %b/%h want 1/%h", bif.byte_valid, bif.byte_out, pb); end
            end
            ready = ~ready;
            pv = bif.byte_valid; pb = bif.byte_out; pr = ready;
            tick(); k++;
        end
        wait_drain(100);
        n_run++; if (got.size() != exp.size()) begin n_fail++; $display("FAIL bp_len: got %0d want %0d", got.size(), exp.size()); end
        foreach (exp[i]) begin
            n_run++;
            if (i >= got.size() || got[i] !== exp[i]) begin n_fail++; $display("FAIL bp_byte[%0d]: got %h want %h", i, (i < got.size()) ? got[i] : 8'h00, exp[i]); end
        end
        got.delete(); exp.delete();
    endtask

    task automatic test_overflow();
        logic [63:0] errs [5] = '{64'd1000, 64'd1001, 64'd1002, 64'd1003, 64'd3};
        ready = 1'b0;
        strobe(64'd2000, 16'h000A, 64'd0, 1'b0, 1'b1);
        repeat (2) tick();
        n_run++; if (bif.byte_valid !== 1'b1 || fifo_count !== 0) begin n_fail++; $display("FAIL ovf_stall: got %b/%0d want 1/0", bif.byte_valid, fifo_count); end
        for (int k = 0; k < 5; k++) begin
            strobe(errs[k], CFG_W'(16'h20 + k), 64'd1002, 1'b0, k < 4);
            n_run++; if (fifo_count !== ((k < 4) ? k + 1 : 4)) begin n_fail++; $display("FAIL ovf_count[%0d]: got %0d want %0d", k, fifo_count, (k < 4) ? k + 1 : 4); end
            n_run++; if (overflow !== (k == 4)) begin n_fail++; $display("FAIL ovf_flag[%0d]: got %b want %b", k, overflow, k == 4); end
        end
        n_run++; if (last_pass !== m_pass) begin n_fail++; $display("FAIL ovf_last_pass: got %b want %b", last_pass, m_pass); end
        n_run++; if (best_err !== m_best || best_id !== m_id) begin n_fail++; $display("FAIL ovf_best: got %h/%h want %h/%h", best_err, best_id, m_best, m_id); end
        clear = 1'b1; tick(); clear = 1'b0;
        m_bv = 1'b0; m_best = '0; m_id = '0;
        n_run++; if (overflow !== 1'b0 || best_valid !== 1'b0) begin n_fail++; $display("FAIL ovf_clear: got %b/%b want 0/0", overflow, best_valid); end
        wait_drain(300);
        n_run++; if (got.size() != exp.size()) begin n_fail++; $display("FAIL ovf_len: got %0d want %0d", got.size(), exp.size()); end
        foreach (exp[i]) begin
            n_run++;
            if (i >= got.size() || got[i] !== exp[i]) begin n_fail++; $display("FAIL ovf_byte[%0d]: got %h want %h", i, (i < got.size()) ? got[i] : 8'h00, exp[i]); end
        end
        got.delete(); exp.delete();
    endtask

    task automatic test_best();
        ready = 1'b1;
        clear = 1'b1; tick(); clear = 1'b0;
        m_bv = 1'b0; m_best = '0; m_id = '0;
        strobe(64'd50, 16'd1, 64'd100, 1'b0, 1'b1);
        strobe(64'd20, 16'd2, 64'd100, 1'b0, 1'b1);
        strobe(64'd20, 16'd3, 64'd100, 1'b0, 1'b1);
        n_run++; if (best_err !== 64'd20 || best_id !== 16'd2 || best_valid !== 1'b1) begin n_fail++; $display("FAIL best_tie: got %0d/%0d want 20/2", best_err, best_id); end
        strobe(64'd5, 16'd4, 64'd100, 1'b1, 1'b1);
        n_run++; if (best_valid !== m_bv || best_err !== m_best || best_id !== m_id) begin n_fail++; $display("FAIL best_clear: got %b/%0d want %b/%0d", best_valid, best_err, m_bv, m_best); end
        wait_drain(200);
        n_run++; if (got.size() != exp.size()) begin n_fail++; $display("FAIL best_len: got %0d want %0d", got.size(), exp.size()); end
        foreach (exp[i]) begin
            n_run++;
            if (i >= got.size() || got[i] !== exp[i]) begin n_fail++; $display("FAIL best_byte[%0d]: got %h want %h", i, (i < got.size()) ? got[i] : 8'h00, exp[i]); end
        end
        got.delete(); exp.delete();
    endtask

    task automatic test_reset_mid();
        int k = 0;
        ready = 1'b1;
        strobe(64'hDEAD_BEEF, 16'h0BAD, 64'h0, 1'b0, 1'b0);
        strobe(64'h1234, 16'h0BEE, 64'h0, 1'b0, 1'b0);
        while (got.size() < 3 && k < 20) begin tick(); k++; end
        n_run++; if (got.size() < 3) begin n_fail++; $display("FAIL rm_timeout: got %0d bytes want 3", got.size()); end
        rstn = 1'b0; tick();
        n_run++; if (bif.byte_valid !== 1'b0 || bif.byte_out !== 8'h00) begin n_fail++; $display("FAIL rm_stream: got %b/%h want 0/00", bif.byte_valid, bif.byte_out); end
        n_run++; if (fifo_count !== 0) begin n_fail++; $display("FAIL rm_count: got %0d want 0", fifo_count); end
        n_run++; if ({best_valid, last_pass, overflow} !== 3'b000 || best_err !== '0 || best_id !== '0) begin n_fail++; $display("FAIL rm_outputs: got %b/%h/%h want 000/0/0", {best_valid, last_pass, overflow}, best_err, best_id); end
        rstn = 1'b1;
        got.delete(); exp.delete();
        m_bv = 1'b0; m_best = '0; m_id = '0; m_pass = 1'b0;
        tick();
        strobe(64'hFEDC_BA98_7654_3210, 16'h5A5A, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b1);
        wait_drain(100);
        repeat (10) tick();
        n_run++; if (got.size() != exp.size()) begin n_fail++; $display("FAIL rm_len: got %0d want %0d", got.size(), exp.size()); end
        foreach (exp[i]) begin
            n_run++;
            if (i >= got.size() || got[i] !== exp[i]) begin n_fail++; $display("FAIL rm_byte[%0d]: got %h want %h", i, (i < got.size()) ? got[i] : 8'h00, exp[i]); end
        end
        got.delete(); exp.delete();
    endtask

    task automatic test_random();
        logic [63:0] e, thr;
        for (int it = 0; it < 30; it++) begin
            e = {$urandom, $urandom};
            if ($urandom_range(0, 2) == 0) e = 64'($urandom_range(0, 1000));
            if (m_bv && $urandom_range(0, 3) == 0) e = m_best;
            thr = ($urandom_range(0, 3) == 0) ? e : {$urandom, $urandom};
            ready = 1'($urandom_range(0, 1));
            strobe(e, CFG_W'($urandom), thr, $urandom_range(0, 7) == 0, 1'b1);
            n_run++; if (best_valid !== m_bv || best_err !== m_best || best_id !== m_id) begin n_fail++; $display("FAIL rnd_best[%0d]: got %b/%h/%h want %b/%h/%h", it, best_valid, best_err, best_id, m_bv, m_best, m_id); end
            n_run++; if (last_pass !== m_pass || overflow !== 1'b0) begin n_fail++; $display("FAIL rnd_flags[%0d]: got %b/%b want %b/0", it, last_pass, overflow, m_pass); end
            repeat (40) begin ready = 1'($urandom_range(0, 1)); tick(); end
        end
        wait_drain(400);
        n_run++; if (got.size() != exp.size()) begin n_fail++; $display("FAIL rnd_len: got %0d want %0d", got.size(), exp.size()); end
        foreach (exp[i]) begin
            n_run++;
            if (i >= got.size() || got[i] !== exp[i]) begin n_fail++; $display("FAIL rnd_byte[%0d]: got %h want %h", i, (i < got.size()) ? got[i] : 8'h00, exp[i]); end
        end
        got.delete(); exp.delete();
    endtask

    initial begin
        test_reset();
        test_single();
        test_pass_boundary();
        test_backpressure();
        test_overflow();
        test_best();
        test_reset_mid();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
